// File: rtl/des_pkg.sv
// des_pkg: DES vector typedefs, the E-expansion and P-permutation tables,
// and the helpers that apply them (bit 1 of every vector is the MSB).
package des_pkg;

    typedef logic [1:32] des_w32_t;
    typedef logic [1:48] des_w48_t;
    typedef logic [1:6]  des_w6_t;
    typedef logic [5:0]  des_idx_t;

    localparam des_idx_t E_TAB [48] = '{
        6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,
        6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
        6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13,
        6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
        6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
        6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
    };

    localparam des_idx_t P_TAB [32] = '{
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

    function automatic des_w48_t e_expand(input des_w32_t r);
        des_w48_t e;
        e = '0;
        for (int i = 0; i < 48; i++) begin
            e[6'(i + 1)] = r[E_TAB[6'(i)]];
        end
        return e;
    endfunction

    function automatic des_w32_t p_permute(input des_w32_t s);
        des_w32_t p;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            p[6'(i + 1)] = s[P_TAB[5'(i)]];
        end
        return p;
    endfunction

endpackage

// File: rtl/des_f_pipe_if.sv
// des_f_pipe_if: valid/ready bundle around des_f_pipe; the pipe uses the slave
// modport, the upstream round controller / downstream L-R logic use master.
interface des_f_pipe_if #(
    parameter int TAG_W = 4
);
    import des_pkg::*;

    logic             in_valid;
    logic             in_ready;
    des_w32_t         r_in;
    des_w48_t         k_in;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    des_w32_t         f_out;
    logic [TAG_W-1:0] tag_out;

    modport slave (
        input  in_valid, r_in, k_in, tag_in, out_ready,
        output in_ready, out_valid, f_out, tag_out
    );

    modport master (
        output in_valid, r_in, k_in, tag_in, out_ready,
        input  in_ready, out_valid, f_out, tag_out
    );

endinterface

// File: rtl/des_sbox_bank.sv
// des_sbox_bank: combinational S1..S8 lookup, 48-bit x in, 32-bit S vector out.
// Each box table is stored row-major, entry 0 in the top nibble.
module des_sbox_bank
    import des_pkg::*;
(
    input  des_w48_t x_in,
    output des_w32_t s_out
);

    localparam logic [255:0] SBOX_TAB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Row is {b1,b6}, column b2..b5; entry k sits at bit 4*(63-k).
    function automatic logic [3:0] sbox_lookup(input logic [255:0] tab, input des_w6_t b);
        logic [5:0] idx;
        idx = {b[1], b[6], b[2], b[3], b[4], b[5]};
        return tab[{~idx, 2'b00} +: 4];
    endfunction

    for (genvar g = 0; g < 8; g++) begin : g_sbox
        assign s_out[4*g+1 +: 4] = sbox_lookup(SBOX_TAB[g], x_in[6*g+1 +: 6]);
    end

endmodule

// File: rtl/des_f_pipe.sv
// des_f_pipe: pipelined DES round function f(R,K) = P(S(E(R) ^ K)) with valid/ready.
// Define DES_F_PIPE_SINGLE_STAGE_EN to drop the stage-1 register (latency 1, capacity 1).
module des_f_pipe
    import des_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    des_f_pipe_if.slave bus
);

    logic             in_ready_s;
    logic             in_fire_s;
    logic             s2_adv_s;
    des_w48_t         sbox_x_s;
    des_w32_t         sbox_s_s;
    logic [TAG_W-1:0] s2_tag_s;

    logic             out_valid_d;
    logic             out_valid_q;
    des_w32_t         f_d;
    des_w32_t         f_q;
    logic [TAG_W-1:0] tag_d;
    logic [TAG_W-1:0] tag_q;

`ifdef DES_F_PIPE_SINGLE_STAGE_EN
    // Without stage 1 the output slot alone decides whether a new operation fits.
    always_comb begin
        in_ready_s = !out_valid_q || bus.out_ready;
        in_fire_s  = bus.in_valid && in_ready_s;
        s2_adv_s   = in_fire_s;
        sbox_x_s   = e_expand(bus.r_in) ^ bus.k_in;
        s2_tag_s   = bus.tag_in;
    end
`else
    logic             s1_valid_d;
    logic             s1_valid_q;
    des_w48_t         s1_x_d;
    des_w48_t         s1_x_q;
    logic [TAG_W-1:0] s1_tag_d;
    logic [TAG_W-1:0] s1_tag_q;

    // Stage 1 may refill in the same cycle it hands its entry to the output register.
    always_comb begin
        s2_adv_s   = s1_valid_q && (!out_valid_q || bus.out_ready);
        in_ready_s = !s1_valid_q || s2_adv_s;
        in_fire_s  = bus.in_valid && in_ready_s;
        if (in_fire_s) begin
            s1_valid_d = 1'b1;
            s1_x_d     = e_expand(bus.r_in) ^ bus.k_in;
            s1_tag_d   = bus.tag_in;
        end else begin
            s1_valid_d = s1_valid_q && !s2_adv_s;
            s1_x_d     = s1_x_q;
            s1_tag_d   = s1_tag_q;
        end
        sbox_x_s = s1_x_q;
        s2_tag_s = s1_tag_q;
    end

    // Stage-1 register: expanded-and-keyed x plus its tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_tag_q   <= s1_tag_d;
        end
    end
`endif

    des_sbox_bank u_sbox_bank (
        .x_in  (sbox_x_s),
        .s_out (sbox_s_s)
    );

    // Output slot: load on advance, otherwise hold data and drop valid once drained.
    always_comb begin
        if (s2_adv_s) begin
            out_valid_d = 1'b1;
            f_d         = p_permute(sbox_s_s);
            tag_d       = s2_tag_s;
        end else begin
            out_valid_d = out_valid_q && !bus.out_ready;
            f_d         = f_q;
            tag_d       = tag_q;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            f_q         <= '0;
            tag_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            f_q         <= f_d;
            tag_q       <= tag_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.f_out     = f_q;
    assign bus.tag_out   = tag_q;

endmodule
